// File: rtl/fsm_bus_pkg.sv
// Shared types and helpers for the flash/SRAM parallel bus controller.
package fsm_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StRdyWait,
    StHold,
    StErr
  } state_e;

  localparam int unsigned CS_FLASH = 0;
  localparam int unsigned CS_SRAM  = 1;

  // Widest packed per-chip-select config vector the helper accepts.
  localparam int unsigned FieldVecW = 256;

  // Extract field idx of width w from a packed per-chip-select vector.
  function automatic logic [31:0] get_field(input logic [FieldVecW-1:0] vec,
                                            input int unsigned idx,
                                            input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return 32'(vec >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/fsm_bus_ctrl_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset and configurable reset value.
module fsm_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= ResetVal;
      s2_q <= ResetVal;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/fsm_bus_ctrl.sv
// Single-beat request controller for the shared flash/SRAM parallel bus with
// per-chip-select wait states and optional ready/busy wait with timeout.
module fsm_bus_ctrl
  import fsm_bus_pkg::*;
#(
  parameter int unsigned AW   = 26,
  parameter int unsigned DW   = 32,
  parameter int unsigned NCS  = 2,
  parameter int unsigned CSW  = 1,
  parameter int unsigned WS_W = 4,
  parameter int unsigned TO_W = 12
) (
  input  logic                sys0_clk,
  input  logic                sys0_rstn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [CSW-1:0]      req_cs,
  input  logic [AW-1:0]       req_addr,
  input  logic [DW-1:0]       req_wdata,
  input  logic [DW/8-1:0]     req_be,
  output logic                rsp_valid,
  output logic [DW-1:0]       rsp_rdata,
  output logic                rsp_err,
  input  logic [NCS*WS_W-1:0] cfg_rd_ws,
  input  logic [NCS*WS_W-1:0] cfg_wr_ws,
  input  logic [NCS-1:0]      cfg_rdy_en,
  output logic [AW-1:0]       fsm_a,
  output logic [DW-1:0]       fsm_d_o,
  output logic                fsm_d_oe,
  input  logic [DW-1:0]       fsm_d_i,
  output logic [NCS-1:0]      fsm_ce_n,
  output logic                fsm_oe_n,
  output logic                fsm_we_n,
  output logic [DW/8-1:0]     fsm_be_n,
  input  logic                fsm_rdybsy_n
);

  localparam int unsigned BW = DW / 8;

  state_e          state_q, state_d;
  logic            write_q, rdy_en_q;
  logic [CSW-1:0]  cs_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [BW-1:0]   be_q;
  logic [WS_W-1:0] ws_q, ws_sel;
  logic [WS_W-1:0] wcnt_q, wcnt_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            rdy_sync, rdy_en_sel, cs_ok, accept;
  logic            bus_active, strobe;

  fsm_sync2 #(
    .ResetVal(1'b1)
  ) u_rdy_sync (
    .clk_i (sys0_clk),
    .rst_ni(sys0_rstn),
    .d_i   (fsm_rdybsy_n),
    .q_o   (rdy_sync)
  );

  assign accept = req_valid && (state_q == StIdle);
  assign cs_ok  = 32'(req_cs) < NCS;

  // Channel config is sampled only at accept so later cfg writes cannot disturb a transfer.
  always_comb begin
    ws_sel     = req_write ? WS_W'(get_field(FieldVecW'(cfg_wr_ws), 32'(req_cs), WS_W))
                           : WS_W'(get_field(FieldVecW'(cfg_rd_ws), 32'(req_cs), WS_W));
    rdy_en_sel = get_field(FieldVecW'(cfg_rdy_en), 32'(req_cs), 1) != 32'd0;
  end

  always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
    if (!sys0_rstn) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      cs_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      ws_q     <= '0;
      rdy_en_q <= 1'b0;
      wcnt_q   <= '0;
      tcnt_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept) begin
        write_q  <= req_write;
        cs_q     <= req_cs;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        be_q     <= req_be;
        ws_q     <= ws_sel;
        rdy_en_q <= rdy_en_sel;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = cs_ok ? StSetup : StErr;
          err_d   = 1'b0;
        end
      end
      StSetup: begin
        wcnt_d  = ws_q;
        state_d = StAccess;
      end
      StAccess: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 1'b1;
        end else if (rdy_en_q && !rdy_sync) begin
          tcnt_d  = '0;
          state_d = StRdyWait;
        end else begin
          if (!write_q) rdata_d = fsm_d_i;
          err_d   = 1'b0;
          state_d = StHold;
        end
      end
      StRdyWait: begin
        // Ready takes priority over a coincident timeout.
        if (rdy_sync) begin
          if (!write_q) rdata_d = fsm_d_i;
          err_d   = 1'b0;
          state_d = StHold;
        end else if (tcnt_q == '1) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StHold;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StHold:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_active = (state_q == StSetup) || (state_q == StAccess) ||
                 (state_q == StRdyWait) || (state_q == StHold);
    strobe     = (state_q == StAccess) || (state_q == StRdyWait);

    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StHold) || (state_q == StErr);
    rsp_err   = (state_q == StErr) || ((state_q == StHold) && err_q);
    rsp_rdata = rdata_q;

    fsm_a    = bus_active ? addr_q : '0;
    fsm_be_n = bus_active ? ~be_q : '1;
    fsm_d_oe = bus_active && write_q;
    fsm_d_o  = (bus_active && write_q) ? wdata_q : '0;
    fsm_oe_n = !(strobe && !write_q);
    fsm_we_n = !(strobe && write_q);
    fsm_ce_n = '1;
    for (int unsigned i = 0; i < NCS; i++) begin
      if (bus_active && (cs_q == CSW'(i))) fsm_ce_n[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_fsm_bus_ctrl.sv
// Directed bench for fsm_bus_ctrl: reads, writes, ready-wait, timeout, bad chip select, reset abort.
module tb_fsm_bus_ctrl;
  import fsm_bus_pkg::*;

  localparam int unsigned AW = 26, DW = 32, NCS = 2, CSW = 2, WS_W = 4, TO_W = 4;

  logic                sys0_clk = 1'b0;
  logic                sys0_rstn;
  logic                req_valid, req_ready, req_write;
  logic [CSW-1:0]      req_cs;
  logic [AW-1:0]       req_addr;
  logic [DW-1:0]       req_wdata;
  logic [DW/8-1:0]     req_be;
  logic                rsp_valid, rsp_err;
  logic [DW-1:0]       rsp_rdata;
  logic [NCS*WS_W-1:0] cfg_rd_ws, cfg_wr_ws;
  logic [NCS-1:0]      cfg_rdy_en;
  logic [AW-1:0]       fsm_a;
  logic [DW-1:0]       fsm_d_o, fsm_d_i;
  logic                fsm_d_oe, fsm_oe_n, fsm_we_n, fsm_rdybsy_n;
  logic [NCS-1:0]      fsm_ce_n;
  logic [DW/8-1:0]     fsm_be_n;

  int n_checks = 0;
  int n_fail   = 0;
  int we_low;

  fsm_bus_ctrl #(
    .AW(AW), .DW(DW), .NCS(NCS), .CSW(CSW), .WS_W(WS_W), .TO_W(TO_W)
  ) dut (
    .sys0_clk    (sys0_clk),
    .sys0_rstn   (sys0_rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_cs      (req_cs),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_be      (req_be),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .cfg_rd_ws   (cfg_rd_ws),
    .cfg_wr_ws   (cfg_wr_ws),
    .cfg_rdy_en  (cfg_rdy_en),
    .fsm_a       (fsm_a),
    .fsm_d_o     (fsm_d_o),
    .fsm_d_oe    (fsm_d_oe),
    .fsm_d_i     (fsm_d_i),
    .fsm_ce_n    (fsm_ce_n),
    .fsm_oe_n    (fsm_oe_n),
    .fsm_we_n    (fsm_we_n),
    .fsm_be_n    (fsm_be_n),
    .fsm_rdybsy_n(fsm_rdybsy_n)
  );

  always #5 sys0_clk = ~sys0_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys0_clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [CSW-1:0] cs, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW/8-1:0] be);
    req_write = wr;
    req_cs    = cs;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, " ce_n"}, 64'(fsm_ce_n), 64'h3);
    chk({tag, " oe_n"}, 64'(fsm_oe_n), 64'h1);
    chk({tag, " we_n"}, 64'(fsm_we_n), 64'h1);
    chk({tag, " be_n"}, 64'(fsm_be_n), 64'hF);
    chk({tag, " d_oe"}, 64'(fsm_d_oe), 64'h0);
    chk({tag, " a"},    64'(fsm_a),    64'h0);
    chk({tag, " d_o"},  64'(fsm_d_o),  64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys0_rstn    = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_cs       = '0;
    req_addr     = '0;
    req_wdata    = '0;
    req_be       = '0;
    cfg_rd_ws    = {4'd0, 4'd1};   // cs1 = 0, cs0 = 1
    cfg_wr_ws    = {4'd5, 4'd3};   // cs1 = 5, cs0 = 3
    cfg_rdy_en   = 2'b00;
    fsm_d_i      = 32'hCAFEF00D;
    fsm_rdybsy_n = 1'b1;

    // Reset state
    #12;
    chk_idle_bus("rst");
    chk("rst req_ready", 64'(req_ready), 64'h1);
    chk("rst rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst rsp_err",   64'(rsp_err),   64'h0);
    chk("rst rsp_rdata", 64'(rsp_rdata), 64'h0);
    @(negedge sys0_clk);
    sys0_rstn = 1'b1;
    tick();

    // Read, SRAM, ws=0, no ready-wait
    issue(1'b0, CSW'(CS_SRAM), 26'h123456, 32'h0, 4'hF);
    chk("t1 c1 ce_n",  64'(fsm_ce_n),  64'h1);
    chk("t1 c1 oe_n",  64'(fsm_oe_n),  64'h1);
    chk("t1 c1 a",     64'(fsm_a),     64'h123456);
    chk("t1 c1 ready", 64'(req_ready), 64'h0);
    chk("t1 c1 d_oe",  64'(fsm_d_oe),  64'h0);
    tick();
    chk("t1 c2 ce_n",  64'(fsm_ce_n),  64'h1);
    chk("t1 c2 oe_n",  64'(fsm_oe_n),  64'h0);
    chk("t1 c2 d_oe",  64'(fsm_d_oe),  64'h0);
    chk("t1 c2 valid", 64'(rsp_valid), 64'h0);
    tick();
    chk("t1 c3 ce_n",  64'(fsm_ce_n),  64'h1);
    chk("t1 c3 oe_n",  64'(fsm_oe_n),  64'h1);
    chk("t1 c3 valid", 64'(rsp_valid), 64'h1);
    chk("t1 c3 rdata", 64'(rsp_rdata), 64'hCAFEF00D);
    chk("t1 c3 err",   64'(rsp_err),   64'h0);
    tick();
    chk_idle_bus("t1 c4");
    chk("t1 c4 valid", 64'(rsp_valid), 64'h0);
    chk("t1 c4 ready", 64'(req_ready), 64'h1);
    chk("t1 c4 rdata", 64'(rsp_rdata), 64'hCAFEF00D);

    // Write, flash, ws=3; cfg change after accept must not matter
    we_low = 0;
    issue(1'b1, CSW'(CS_FLASH), 26'h0ABCDE, 32'h12345678, 4'b0011);
    cfg_wr_ws = {4'd5, 4'd0};
    for (int c = 1; c <= 7; c++) begin
      if (!fsm_we_n) we_low++;
      chk($sformatf("t2 c%0d we_n", c),  64'(fsm_we_n),  64'((c >= 2 && c <= 5) ? 0 : 1));
      chk($sformatf("t2 c%0d d_oe", c),  64'(fsm_d_oe),  64'((c <= 6) ? 1 : 0));
      chk($sformatf("t2 c%0d oe_n", c),  64'(fsm_oe_n),  64'h1);
      chk($sformatf("t2 c%0d valid", c), 64'(rsp_valid), 64'((c == 6) ? 1 : 0));
      chk($sformatf("t2 c%0d be_n", c),  64'(fsm_be_n),  64'((c <= 6) ? 4'b1100 : 4'b1111));
      chk($sformatf("t2 c%0d d_o", c),   64'(fsm_d_o),   64'((c <= 6) ? 32'h12345678 : 32'h0));
      chk($sformatf("t2 c%0d ce_n", c),  64'(fsm_ce_n),  64'((c <= 6) ? 2'b10 : 2'b11));
      if (c == 6) chk("t2 err", 64'(rsp_err), 64'h0);
      tick();
    end
    chk("t2 we_n low cycles", 64'(we_low), 64'd4);
    chk("t2 rdata held", 64'(rsp_rdata), 64'hCAFEF00D);

    // Read, flash, ws=1, ready-wait; device ready rises in cycle 14
    cfg_rdy_en   = 2'b01;
    fsm_d_i      = 32'hA5A55A5A;
    fsm_rdybsy_n = 1'b0;
    tick();
    tick();
    tick();
    issue(1'b0, CSW'(CS_FLASH), 26'h000040, 32'h0, 4'hF);
    for (int c = 1; c <= 18; c++) begin
      chk($sformatf("t3 c%0d oe_n", c),  64'(fsm_oe_n),  64'((c >= 2 && c <= 16) ? 0 : 1));
      chk($sformatf("t3 c%0d valid", c), 64'(rsp_valid), 64'((c == 17) ? 1 : 0));
      chk($sformatf("t3 c%0d d_oe", c),  64'(fsm_d_oe),  64'h0);
      if (c == 17) begin
        chk("t3 err",   64'(rsp_err),   64'h0);
        chk("t3 rdata", 64'(rsp_rdata), 64'hA5A55A5A);
      end
      if (c == 14) fsm_rdybsy_n = 1'b1;
      tick();
    end

    // Same read, device stays busy: 16-cycle timeout
    fsm_rdybsy_n = 1'b0;
    fsm_d_i      = 32'h11223344;
    tick();
    tick();
    tick();
    issue(1'b0, CSW'(CS_FLASH), 26'h000080, 32'h0, 4'hF);
    for (int c = 1; c <= 21; c++) begin
      chk($sformatf("t4 c%0d oe_n", c),  64'(fsm_oe_n),  64'((c >= 2 && c <= 19) ? 0 : 1));
      chk($sformatf("t4 c%0d valid", c), 64'(rsp_valid), 64'((c == 20) ? 1 : 0));
      if (c == 20) begin
        chk("t4 err",   64'(rsp_err),   64'h1);
        chk("t4 rdata", 64'(rsp_rdata), 64'h0);
      end
      if (c == 21) chk_idle_bus("t4 c21");
      tick();
    end
    fsm_rdybsy_n = 1'b1;
    cfg_rdy_en   = 2'b00;
    tick();
    tick();

    // Bad chip select
    issue(1'b0, 2'd3, 26'h000100, 32'h0, 4'hF);
    chk("t5 c1 valid", 64'(rsp_valid), 64'h1);
    chk("t5 c1 err",   64'(rsp_err),   64'h1);
    chk("t5 c1 ce_n",  64'(fsm_ce_n),  64'h3);
    chk("t5 c1 ready", 64'(req_ready), 64'h0);
    chk("t5 c1 oe_n",  64'(fsm_oe_n),  64'h1);
    tick();
    chk("t5 c2 valid", 64'(rsp_valid), 64'h0);
    chk("t5 c2 ready", 64'(req_ready), 64'h1);

    // Reset during ACCESS of a write, then a normal read
    issue(1'b1, CSW'(CS_SRAM), 26'h000200, 32'hDEADBEEF, 4'hF);
    tick();
    chk("t6 pre we_n", 64'(fsm_we_n), 64'h0);
    sys0_rstn = 1'b0;
    #1;
    chk_idle_bus("t6 rst");
    chk("t6 rst valid", 64'(rsp_valid), 64'h0);
    chk("t6 rst ready", 64'(req_ready), 64'h1);
    chk("t6 rst rdata", 64'(rsp_rdata), 64'h0);
    tick();
    tick();
    sys0_rstn = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("t6 post c%0d valid", c), 64'(rsp_valid), 64'h0);
      chk($sformatf("t6 post c%0d ce_n", c),  64'(fsm_ce_n),  64'h3);
      tick();
    end
    fsm_d_i = 32'h0BADBEEF;
    issue(1'b0, CSW'(CS_SRAM), 26'h000300, 32'h0, 4'hF);
    tick();
    tick();
    chk("t6 rd valid", 64'(rsp_valid), 64'h1);
    chk("t6 rd rdata", 64'(rsp_rdata), 64'h0BADBEEF);
    chk("t6 rd err",   64'(rsp_err),   64'h0);
    tick();
    chk("t6 rd ready", 64'(req_ready), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_bus_ctrl.md
Name: fsm_bus_ctrl

Overview:
- Parametrised controller for the shared flash/SRAM (FSM) parallel bus on the board top level.
- Takes single-beat read/write requests from the control plane.
- Generates chip enables per device, output/write strobes, byte enables and the tristate data control.
- Supports per-chip-select programmable wait states and optional ready/busy wait with timeout. This supersedes the fixed flash-only pin hookup.

Parameters:
- AW, 26, bus address width (fsm_a).
- DW, 32, bus data width; a multiple of 8.
- NCS, 2, number of chip selects; index 0 is flash, index 1 is SRAM.
- CSW, 1, width of req_cs; must satisfy 2**CSW >= NCS.
- WS_W, 4, width of each wait-state field.
- TO_W, 12, width of the ready-wait timeout counter.

Ports:
- sys0_clk  in  1  single clock, rising edge.
- sys0_rstn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  controller idle; a request is accepted when req_valid and req_ready are both high.
- req_write  in  1  1 = write, 0 = read.
- req_cs  in  CSW  target chip-select index.
- req_addr  in  AW  bus address.
- req_wdata  in  DW  write data.
- req_be  in  DW/8  active-high byte enables.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DW  read data; valid while rsp_valid is high.
- rsp_err  out  1  timeout or bad chip select; valid while rsp_valid is high.
- cfg_rd_ws  in  NCS*WS_W  read wait states per chip select.
- cfg_wr_ws  in  NCS*WS_W  write wait states per chip select.
- cfg_rdy_en  in  NCS  enable ready/busy wait per chip select.
- fsm_a  out  AW  bus address.
- fsm_d_o  out  DW  bus write data.
- fsm_d_oe  out  1  data-bus output enable (drives the pad tristate).
- fsm_d_i  in  DW  bus read data.
- fsm_ce_n  out  NCS  active-low chip enables.
- fsm_oe_n  out  1  active-low output enable.
- fsm_we_n  out  1  active-low write enable.
- fsm_be_n  out  DW/8  active-low byte lanes.
- fsm_rdybsy_n  in  1  device ready (1) or busy (0); asynchronous to sys0_clk.

Behaviour:
- Reset values (applied asynchronously on sys0_rstn low, including mid-transaction):
  - req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - fsm_ce_n all 1, fsm_oe_n=1, fsm_we_n=1, fsm_be_n all 1, fsm_d_oe=0, fsm_a=0, fsm_d_o=0.
  - State returns to IDLE; no response is issued for an aborted transaction.
- fsm_rdybsy_n passes through a 2-flop synchronizer (reset value 1); only the synchronized value is used.
- On acceptance, latch write, cs, addr, wdata, be and the selected channel's ws and rdy_en. Config changes do not affect a transaction in flight.
- FSM states: IDLE, SETUP, ACCESS, RDYWAIT, HOLD, ERR.
- IDLE: req_ready=1 only in this state.
  - On accept with cs >= NCS, go to ERR.
  - Otherwise go to SETUP.
- ERR: rsp_valid=1, rsp_err=1, no bus activity; then IDLE.
- SETUP (1 cycle):
  - fsm_a=addr; fsm_ce_n[cs]=0; fsm_be_n=~be.
  - For writes: fsm_d_oe=1, fsm_d_o=wdata.
  - Strobes stay high. Load wait counter with ws.
- ACCESS (ws+1 cycles):
  - fsm_oe_n=0 for reads, fsm_we_n=0 for writes.
  - Counter decrements each cycle; leave ACCESS when it is 0.
  - On leaving, if rdy_en and the synchronized ready is 0, go to RDYWAIT with strobes held and the timeout counter cleared.
  - Otherwise capture fsm_d_i into rsp_rdata (reads only) and go to HOLD.
- RDYWAIT:
  - Strobes held; timeout counter increments every cycle.
  - When the synchronized ready is 1: capture read data, go to HOLD, err=0.
  - When the counter reaches 2**TO_W-1: go to HOLD with err=1 and rsp_rdata=0. If ready and timeout occur in the same cycle, ready wins.
- HOLD (1 cycle):
  - Strobes high; ce_n, address, be and write data still driven.
  - rsp_valid=1 and rsp_err=err.
  - Next cycle: all bus outputs return to their reset idle values and the state returns to IDLE.
- Latency from accept edge to rsp_valid:
  - 2 + (ws+1) cycles without ready-wait (ws=0 gives 3).
  - Plus the RDYWAIT cycles when ready-wait is taken.
- fsm_d_oe is never 1 while fsm_oe_n is 0.
- Back-to-back transactions: minimum 1 IDLE cycle between HOLD and the next SETUP, so chip enables deassert between transactions.
- Width rules: unselected fsm_ce_n bits stay 1. rsp_rdata holds its value until the next capture or reset.

Decomposition:
- Package fsm_bus_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, RDYWAIT, HOLD, ERR);
  - CS_FLASH=0 and CS_SRAM=1 constants;
  - a function that extracts a WS_W field from a packed per-chip-select vector.
- Sub-module fsm_sync2: 2-flop synchronizer with async active-low reset and parameterised reset value.

Test Plan:
- Read, cs=1, rd_ws=0, rdy_en=0, fsm_d_i=32'hCAFEF00D → ce_n=2'b01 for 3 cycles, oe_n low 1 cycle, rsp_valid 3 cycles after accept, rdata=32'hCAFEF00D, err=0.
- Write, cs=0, wr_ws=3, be=4'b0011, wdata=32'h12345678 → we_n low exactly 4 cycles, be_n=4'b1100, d_oe=1 through SETUP..HOLD, d_oe=0 whenever oe_n=0, rsp 6 cycles after accept.
- Read, cs=0, rdy_en=1, rdybsy_n held low 10 cycles after ACCESS then high → oe_n stays low until 2 cycles after the rise (synchronizer delay), err=0, correct data captured.
- Same as previous but rdybsy_n never rises, TO_W=4 → RDYWAIT lasts 16 cycles, rsp_err=1, rdata=0, bus returns to idle.
- req_cs=3 with NCS=2, CSW=2 → no chip enable asserted, rsp_valid+rsp_err on the cycle after accept.
- sys0_rstn pulsed low during ACCESS of a write → all bus outputs idle immediately, no rsp_valid, req_ready=1 after release; the next read completes normally.
